// File: rtl/decode_stage.sv
// Instruction-decode stage: register bank with write-through bypass, control decode,
// immediate extension, load-use stall detection and the ID/EX pipeline register.
module decode_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int IMM_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_valid,
    input  logic [31:0]           if_instr,
    input  logic [DATA_W-1:0]     if_pc_plus4,
    input  logic                  flush,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_rw,
    input  logic [DATA_W-1:0]     wb_busw,
    output logic                  stall_out,
    output logic                  ex_valid,
    output logic [3:0]            ex_ctrl,
    output logic [3:0]            m_ctrl,
    output logic [1:0]            wb_ctrl,
    output logic [DATA_W-1:0]     busa,
    output logic [DATA_W-1:0]     busb,
    output logic [DATA_W-1:0]     immed_ext,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [DATA_W-1:0]     ex_pc_plus4
);
    localparam int NREG = 2 ** REG_ADDR_W;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    function automatic logic signed [DATA_W-1:0] sign_ext(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

    logic [DATA_W-1:0] rf [NREG];

    logic [5:0]            opcode_p0;
    logic [REG_ADDR_W-1:0] rs_p0, rt_p0, rd_p0;
    logic [3:0]            ex_ctrl_p0, m_ctrl_p0;
    logic [1:0]            wb_ctrl_p0;
    logic                  uses_rt_p0;
    logic [DATA_W-1:0]     busa_p0, busb_p0;
    logic signed [DATA_W-1:0] imm_p0;
    logic                  hz_p0, bubble_p0;

    logic                  vld_p1;
    logic [3:0]            ex_ctrl_p1, m_ctrl_p1;
    logic [1:0]            wb_ctrl_p1;
    logic [DATA_W-1:0]     busa_p1, busb_p1, imm_p1, pc_p1;
    logic [REG_ADDR_W-1:0] rs_p1, rt_p1, rd_p1;

    // Field positions are fixed by the ISA; only the address width adapts.
    assign opcode_p0 = if_instr[31:26];
    assign rs_p0     = REG_ADDR_W'(if_instr[25:21]);
    assign rt_p0     = REG_ADDR_W'(if_instr[20:16]);
    assign rd_p0     = REG_ADDR_W'(if_instr[15:11]);
    assign imm_p0    = sign_ext(if_instr[IMM_W-1:0]);

    always_comb begin
        ex_ctrl_p0 = 4'b0000;
        m_ctrl_p0  = 4'b0000;
        wb_ctrl_p0 = 2'b00;
        uses_rt_p0 = 1'b0;
        case (opcode_p0)
            OP_RTYPE: begin ex_ctrl_p0 = 4'b1100; wb_ctrl_p0 = 2'b10; uses_rt_p0 = 1'b1; end
            OP_LW:    begin ex_ctrl_p0 = 4'b0001; m_ctrl_p0 = 4'b0010; wb_ctrl_p0 = 2'b11; end
            OP_SW:    begin ex_ctrl_p0 = 4'b0001; m_ctrl_p0 = 4'b0001; uses_rt_p0 = 1'b1; end
            OP_BEQ:   begin ex_ctrl_p0 = 4'b0010; m_ctrl_p0 = 4'b0100; uses_rt_p0 = 1'b1; end
            OP_ADDI:  begin ex_ctrl_p0 = 4'b0001; wb_ctrl_p0 = 2'b10; end
            OP_J:     begin m_ctrl_p0 = 4'b1000; end
            default:  ;
        endcase
    end

    // Write-through bypass lets a same-cycle write-back reach the operands captured this edge.
    always_comb begin
        busa_p0 = rf[rs_p0];
        busb_p0 = rf[rt_p0];
        if (wb_we && wb_rw != '0 && wb_rw == rs_p0) busa_p0 = wb_busw;
        if (wb_we && wb_rw != '0 && wb_rw == rt_p0) busb_p0 = wb_busw;
        if (rs_p0 == '0) busa_p0 = '0;
        if (rt_p0 == '0) busb_p0 = '0;
    end

    assign hz_p0 = if_valid & vld_p1 & m_ctrl_p1[1] & (rt_p1 != '0) &
                   ((rt_p1 == rs_p0) | (uses_rt_p0 & (rt_p1 == rt_p0)));
    assign stall_out = hz_p0 & ~flush;
    assign bubble_p0 = flush | stall_out | ~if_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (wb_we && wb_rw != '0) begin
            rf[wb_rw] <= wb_busw;
        end
    end

    // ID -> EX boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            ex_ctrl_p1 <= '0;
            m_ctrl_p1  <= '0;
            wb_ctrl_p1 <= '0;
            busa_p1    <= '0;
            busb_p1    <= '0;
            imm_p1     <= '0;
            pc_p1      <= '0;
            rs_p1      <= '0;
            rt_p1      <= '0;
            rd_p1      <= '0;
        end else if (bubble_p0) begin
            vld_p1     <= 1'b0;
            ex_ctrl_p1 <= '0;
            m_ctrl_p1  <= '0;
            wb_ctrl_p1 <= '0;
            busa_p1    <= '0;
            busb_p1    <= '0;
            imm_p1     <= '0;
            pc_p1      <= '0;
            rs_p1      <= '0;
            rt_p1      <= '0;
            rd_p1      <= '0;
        end else begin
            vld_p1     <= 1'b1;
            ex_ctrl_p1 <= ex_ctrl_p0;
            m_ctrl_p1  <= m_ctrl_p0;
            wb_ctrl_p1 <= wb_ctrl_p0;
            busa_p1    <= busa_p0;
            busb_p1    <= busb_p0;
            imm_p1     <= imm_p0;
            pc_p1      <= if_pc_plus4;
            rs_p1      <= rs_p0;
            rt_p1      <= rt_p0;
            rd_p1      <= rd_p0;
        end
    end

    assign ex_valid    = vld_p1;
    assign ex_ctrl     = ex_ctrl_p1;
    assign m_ctrl      = m_ctrl_p1;
    assign wb_ctrl     = wb_ctrl_p1;
    assign busa        = busa_p1;
    assign busb        = busb_p1;
    assign immed_ext   = imm_p1;
    assign ex_rs       = rs_p1;
    assign ex_rt       = rt_p1;
    assign ex_rd       = rd_p1;
    assign ex_pc_plus4 = pc_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed steps plus random traffic against a behavioural model.
module tb_decode_stage;
    logic        clk, rst_n, if_valid, flush, wb_we;
    logic [31:0] if_instr, if_pc_plus4, wb_busw;
    logic [4:0]  wb_rw;
    logic        stall_out, ex_valid;
    logic [3:0]  ex_ctrl, m_ctrl;
    logic [1:0]  wb_ctrl;
    logic [31:0] busa, busb, immed_ext, ex_pc_plus4;
    logic [4:0]  ex_rs, ex_rt, ex_rd;

    logic [63:0] pc64, busa64, busb64, imm64, pco64;
    logic        stall64, vld64;
    logic [3:0]  exc64, mc64;
    logic [1:0]  wbc64;
    logic [4:0]  rs64, rt64, rd64;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc_plus4(if_pc_plus4), .flush(flush), .wb_we(wb_we), .wb_rw(wb_rw),
        .wb_busw(wb_busw), .stall_out(stall_out), .ex_valid(ex_valid),
        .ex_ctrl(ex_ctrl), .m_ctrl(m_ctrl), .wb_ctrl(wb_ctrl), .busa(busa),
        .busb(busb), .immed_ext(immed_ext), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_pc_plus4(ex_pc_plus4)
    );

    decode_stage #(.DATA_W(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc_plus4(pc64), .flush(flush), .wb_we(1'b0), .wb_rw(5'd0),
        .wb_busw(64'd0), .stall_out(stall64), .ex_valid(vld64),
        .ex_ctrl(exc64), .m_ctrl(mc64), .wb_ctrl(wbc64), .busa(busa64),
        .busb(busb64), .immed_ext(imm64), .ex_rs(rs64), .ex_rt(rt64),
        .ex_rd(rd64), .ex_pc_plus4(pco64)
    );

    assign pc64 = {32'h0, if_pc_plus4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: register values and the expected ID/EX contents.
    logic [31:0] mrf [32];
    logic        m_vld;
    logic [3:0]  m_ex, m_m;
    logic [1:0]  m_wb;
    logic [31:0] m_a, m_b, m_imm, m_pc;
    logic [4:0]  m_rs, m_rt, m_rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
        m_vld = 0; m_ex = 0; m_m = 0; m_wb = 0;
        m_a = 0; m_b = 0; m_imm = 0; m_pc = 0; m_rs = 0; m_rt = 0; m_rd = 0;
    endtask

    task automatic spec_decode(input logic [5:0] op, output logic [3:0] e, output logic [3:0] m,
                               output logic [1:0] w, output logic ur);
        case (op)
            6'b000000: begin e = 4'b1100; m = 4'b0000; w = 2'b10; ur = 1; end
            6'b100011: begin e = 4'b0001; m = 4'b0010; w = 2'b11; ur = 0; end
            6'b101011: begin e = 4'b0001; m = 4'b0001; w = 2'b00; ur = 1; end
            6'b000100: begin e = 4'b0010; m = 4'b0100; w = 2'b00; ur = 1; end
            6'b001000: begin e = 4'b0001; m = 4'b0000; w = 2'b10; ur = 0; end
            6'b000010: begin e = 4'b0000; m = 4'b1000; w = 2'b00; ur = 0; end
            default:   begin e = 4'b0000; m = 4'b0000; w = 2'b00; ur = 0; end
        endcase
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input int rs, input int rt, input logic [15:0] lo);
        logic [4:0] a, b;
        a = rs[4:0];
        b = rt[4:0];
        return {op, a, b, lo};
    endfunction

    task automatic chk_all(input string tag);
        chk({tag, ".vld"},  ex_valid, m_vld);
        chk({tag, ".ex"},   ex_ctrl, m_ex);
        chk({tag, ".m"},    m_ctrl, m_m);
        chk({tag, ".wb"},   wb_ctrl, m_wb);
        chk({tag, ".busa"}, busa, m_a);
        chk({tag, ".busb"}, busb, m_b);
        chk({tag, ".imm"},  immed_ext, m_imm);
        chk({tag, ".rs"},   ex_rs, m_rs);
        chk({tag, ".rt"},   ex_rt, m_rt);
        chk({tag, ".rd"},   ex_rd, m_rd);
        chk({tag, ".pc"},   ex_pc_plus4, m_pc);
    endtask

    // One clock: drive inputs, check stall before the edge, advance the model, check ID/EX after.
    task automatic cycle(input string tag, input logic v, input logic [31:0] ins, input logic fl,
                         input logic we, input logic [4:0] rw, input logic [31:0] bw);
        logic [3:0] e, m;
        logic [1:0] w;
        logic ur, hz, st;
        logic [31:0] ra, rb;
        logic [4:0] s, t;
        if_valid = v; if_instr = ins; flush = fl; if_pc_plus4 = $urandom;
        wb_we = we; wb_rw = rw; wb_busw = bw;
        #1;
        s = ins[25:21];
        t = ins[20:16];
        spec_decode(ins[31:26], e, m, w, ur);
        hz = v && m_vld && m_m[1] && m_rt != 0 && (m_rt == s || (ur && m_rt == t));
        st = hz && !fl;
        chk({tag, ".stall"}, stall_out, st);
        ra = (s == 0) ? 32'h0 : (we && rw == s) ? bw : mrf[s];
        rb = (t == 0) ? 32'h0 : (we && rw == t) ? bw : mrf[t];
        @(posedge clk);
        if (fl || st || !v) begin
            m_vld = 0; m_ex = 0; m_m = 0; m_wb = 0; m_a = 0; m_b = 0;
            m_imm = 0; m_pc = 0; m_rs = 0; m_rt = 0; m_rd = 0;
        end else begin
            m_vld = 1; m_ex = e; m_m = m; m_wb = w; m_a = ra; m_b = rb;
            m_imm = 32'($signed(ins[15:0])); m_pc = if_pc_plus4;
            m_rs = s; m_rt = t; m_rd = ins[15:11];
        end
        if (we && rw != 0) mrf[rw] = bw;
        #1;
        chk_all(tag);
    endtask

    logic [5:0] ops [7];

    initial begin
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
        model_clear();
        rst_n = 0; if_valid = 0; if_instr = 0; if_pc_plus4 = 0; flush = 0;
        wb_we = 0; wb_rw = 0; wb_busw = 0;

        // Reset held with random inputs.
        for (int i = 0; i < 3; i++) begin
            if_valid = 1; if_instr = $urandom; if_pc_plus4 = $urandom; flush = $urandom_range(0, 1);
            wb_we = 1; wb_rw = 5'($urandom_range(1, 31)); wb_busw = $urandom;
            #1;
            chk("rst.stall", stall_out, 0);
            @(posedge clk); #1;
            chk_all("rst");
        end
        rst_n = 1;

        cycle("addi", 1, mk(6'b001000, 0, 1, 16'hFFFC), 0, 0, 0, 0);
        chk("addi.imm_const", immed_ext, 32'hFFFFFFFC);
        chk("addi.ex_const", ex_ctrl, 4'b0001);

        cycle("wr3", 1, mk(6'b000000, 3, 3, {5'd4, 5'd0, 6'h20}), 0, 1, 5'd3, 32'h1234);
        chk("wr3.busa_const", busa, 32'h1234);
        chk("wr3.busb_const", busb, 32'h1234);

        cycle("wr0", 1, mk(6'b000000, 1, 1, 16'h0), 0, 1, 5'd0, 32'hFFFF);
        cycle("rd0", 1, mk(6'b000000, 0, 0, {5'd4, 5'd0, 6'h20}), 0, 0, 0, 0);
        chk("rd0.busa_const", busa, 0);

        // Load-use pair: one stall cycle, then the add issues.
        cycle("lw", 1, mk(6'b100011, 1, 2, 16'h0), 0, 0, 0, 0);
        cycle("lu.stall", 1, mk(6'b000000, 2, 6, {5'd5, 5'd0, 6'h20}), 0, 0, 0, 0);
        chk("lu.bubble_const", ex_valid, 0);
        cycle("lu.go", 1, mk(6'b000000, 2, 6, {5'd5, 5'd0, 6'h20}), 0, 0, 0, 0);
        chk("lu.go_const", ex_valid, 1);

        cycle("lw2", 1, mk(6'b100011, 1, 2, 16'h0), 0, 0, 0, 0);
        cycle("lw.addi", 1, mk(6'b001000, 8, 7, 16'h1), 0, 0, 0, 0);
        chk("lw.addi_const", ex_valid, 1);

        cycle("lw3", 1, mk(6'b100011, 1, 2, 16'h0), 0, 0, 0, 0);
        cycle("flush", 1, mk(6'b000000, 2, 6, {5'd5, 5'd0, 6'h20}), 1, 0, 0, 0);
        chk("flush.bubble_const", ex_valid, 0);

        // Decode sweep of every defined opcode plus one undefined.
        for (int i = 0; i < 7; i++)
            cycle("sweep", 1, mk(ops[i], i + 1, i + 9, 16'($urandom)), 0, 0, 0, 0);
        cycle("imm64", 1, mk(6'b001000, 1, 1, 16'h8000), 0, 0, 0, 0);
        chk("imm64.const", imm64, 64'hFFFFFFFFFFFF8000);
        chk("imm64.vld", vld64, 1);

        // Reset asserted while a stall is pending.
        cycle("lw4", 1, mk(6'b100011, 1, 2, 16'h0), 0, 0, 0, 0);
        if_instr = mk(6'b000000, 2, 6, {5'd5, 5'd0, 6'h20});
        #1;
        chk("midrst.pre_stall", stall_out, 1);
        rst_n = 0;
        #1;
        model_clear();
        chk("midrst.stall", stall_out, 0);
        chk_all("midrst");
        @(posedge clk); #1;
        chk_all("midrst.held");
        rst_n = 1;
        cycle("postrst", 1, mk(6'b000000, 3, 3, {5'd4, 5'd0, 6'h20}), 0, 0, 0, 0);
        chk("postrst.busa_const", busa, 0);

        // Random traffic with small register numbers to provoke hazards and bypasses.
        for (int i = 0; i < 400; i++) begin
            logic [5:0] op;
            op = ops[$urandom_range(0, 6)];
            cycle("rand", ($urandom_range(0, 99) < 85),
                  mk(op, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom)),
                  ($urandom_range(0, 99) < 10), $urandom_range(0, 1),
                  5'($urandom_range(0, 7)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, pipelined instruction-decode stage for the five-stage MIPS/DLX core. It sits between the IF/ID and ID/EX boundaries and contains the register bank (with write-through bypass), the main control decoder and the immediate extender. It also contains load-use hazard detection with stall generation and flush handling. All results are registered into an ID/EX pipeline register that this block owns.

## Interface
Parameters:
- DATA_W, 32, datapath and register width
- REG_ADDR_W, 5, register address width; the register count is 2**REG_ADDR_W
- IMM_W, 16, immediate field width (instr[IMM_W-1:0])

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- if_valid  in  1  IF/ID holds a real instruction
- if_instr  in  32  instruction word
- if_pc_plus4  in  DATA_W  PC+4 of that instruction
- flush  in  1  squash the instruction currently in ID (taken branch)
- wb_we  in  1  write-back enable
- wb_rw  in  REG_ADDR_W  write-back register
- wb_busw  in  DATA_W  write-back data
- stall_out  out  1  combinational; IF and IF/ID must hold
- ex_valid  out  1  ID/EX holds a real instruction
- ex_ctrl  out  4  {reg_dst, alu_op[1:0], alu_src}
- m_ctrl  out  4  {jump, branch, mem_read, mem_write}
- wb_ctrl  out  2  {reg_write, mem_to_reg}
- busa, busb  out  DATA_W  register operands
- immed_ext  out  DATA_W  extended immediate
- ex_rs, ex_rt, ex_rd  out  REG_ADDR_W  instr[25:21], [20:16], [15:11]
- ex_pc_plus4  out  DATA_W  forwarded PC+4

## Operation
- Opcode decode uses instr[31:26]. Each entry below gives ex_ctrl / m_ctrl / wb_ctrl:
  - 000000 R-type: 1100 / 0000 / 10
  - 100011 lw: 0001 / 0010 / 11
  - 101011 sw: 0001 / 0001 / 00
  - 000100 beq: 0010 / 0100 / 00
  - 001000 addi: 0001 / 0000 / 10
  - 000010 j: 0000 / 1000 / 00
  - any other opcode: all zeros, with ex_valid still 1.
- uses_rt is 1 for R-type, sw and beq, and 0 for all other opcodes. rs is always treated as a source.
- Immediate: immed_ext = sign-extension of instr[IMM_W-1:0] to DATA_W.
- Register bank:
  - Register 0 always reads 0, and writes to it are ignored.
  - A write occurs on the clock edge when wb_we=1 and wb_rw≠0.
  - Read bypass: if wb_we=1 and wb_rw≠0 equals the read address, the read returns wb_busw in the same cycle.
- Hazard: hz = if_valid & ex_valid & m_ctrl[1] & (ex_rt≠0) & (ex_rt==instr rs | (uses_rt & ex_rt==instr rt)).
- stall_out = hz & ~flush.
- ID/EX load priority on each edge:
  1. If flush, or stall_out, or ~if_valid: load a bubble. A bubble sets ex_valid=0 and all ctrl fields to 0; the data fields are don't-care but are loaded as 0.
  2. Otherwise: load the decoded instruction with ex_valid=1.
- A stall lasts exactly one cycle per load-use pair. After the bubble, hz falls because ex_valid=0.

## Timing
- Reset (rst_n=0, asynchronous): all ID/EX outputs are 0 and all registers are 0. stall_out is 0 while in reset.
- Latency: an instruction present at edge N appears on the ex_* outputs after edge N.
- stall_out is combinational from if_instr, if_valid, flush and the ID/EX state. There is no path from wb_* to stall_out.
- A write-back at edge N and a decode of the same register in the cycle before edge N: the decoded operand captured at edge N is wb_busw.
- flush and hz in the same cycle: flush wins, stall_out=0, and a bubble is loaded.
- Reset asserted mid-stall: the bubble and all state clear immediately. Once rst_n is released, the first edge samples if_* normally.
- DATA_W>32 or REG_ADDR_W≠5: field positions in instr are fixed. Only the register-file depth and the extension width scale.

## Test plan
- Reset: hold rst_n=0 with random inputs → all outputs 0. After release, decode addi $1,$0,-4 → immed_ext=0xFFFFFFFC, ex_ctrl=0001, wb_ctrl=10, busa=0.
- Write then read: wb_we=1, wb_rw=3, wb_busw=0x1234, and decode add $4,$3,$3 in the same cycle → busa=busb=0x1234 after the edge. Writing register 0 with 0xFFFF → later reads of $0 return 0.
- Load-use: lw $2,0($1) followed by add $5,$2,$6 →
  - stall_out=1 for one cycle;
  - the next ID/EX is a bubble (ex_valid=0);
  - the add follows with ex_valid=1.
  - Also lw $2 followed by addi $7,$8,1 → no stall.
- Flush priority: the same load-use pair with flush=1 in the hazard cycle → stall_out=0 and ID/EX gets a bubble.
- Decode sweep: each of the six defined opcodes plus opcode 111111 → the exact ctrl tuples listed above. Check that ex_rs, ex_rt, ex_rd and ex_pc_plus4 pass through.
- Parameters: with DATA_W=64, immediate 0x8000 → immed_ext=0xFFFFFFFFFFFF8000.
